axi_sram_slv: RTL and testbench



---
 rtl/axi_sram_slv.sv | 268 ++++++++++++++++++++++++++
 tb/tb_axi_sram_slv.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slv.sv
// -----------------------------------------------------------------------------
// axi_sram_slv
//   AXI4 responder serving one burst at a time from an on-chip single-port SRAM
//   (32-bit data, byte write enables, 1-cycle registered read latency).
//   Write and read address channels are arbitrated round-robin. Beat addresses
//   are generated for FIXED/INCR/WRAP bursts. A 2-entry read skid buffer keeps
//   one beat per cycle flowing while absorbing rready backpressure.
//
// Ports
//   clk, rstn                     clock, asynchronous active-low reset
//   s_aw*  / s_awready            write address channel
//   s_w*   / s_wready             write data channel
//   s_b*   / s_bready             write response channel
//   s_ar*  / s_arready            read address channel
//   s_r*   / s_rready             read data channel
//   mem_cs, mem_we, mem_addr,     SRAM port (mem_we = 0 means read; mem_rdata
//   mem_wdata, mem_rdata          is valid the cycle after a read mem_cs)
// -----------------------------------------------------------------------------
module axi_sram_slv #(
  parameter int ID_WIDTH = 6,
  parameter int MEM_AW   = 15
) (
  input  logic                clk,
  input  logic                rstn,
  // write address
  input  logic [ID_WIDTH-1:0] s_awid,
  input  logic [31:0]         s_awaddr,
  input  logic [7:0]          s_awlen,
  input  logic [2:0]          s_awsize,
  input  logic [1:0]          s_awburst,
  input  logic                s_awvalid,
  output logic                s_awready,
  // write data
  input  logic [31:0]         s_wdata,
  input  logic [3:0]          s_wstrb,
  input  logic                s_wlast,
  input  logic                s_wvalid,
  output logic                s_wready,
  // write response
  output logic [ID_WIDTH-1:0] s_bid,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  // read address
  input  logic [ID_WIDTH-1:0] s_arid,
  input  logic [31:0]         s_araddr,
  input  logic [7:0]          s_arlen,
  input  logic [2:0]          s_arsize,
  input  logic [1:0]          s_arburst,
  input  logic                s_arvalid,
  output logic                s_arready,
  // read data
  output logic [ID_WIDTH-1:0] s_rid,
  output logic [31:0]         s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rlast,
  output logic                s_rvalid,
  input  logic                s_rready,
  // SRAM port
  output logic                mem_cs,
  output logic [3:0]          mem_we,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata
);

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t                state_reg, state_next;
  logic                  prio_w_reg;
  logic [ID_WIDTH-1:0]   id_reg;
  logic [31:0]           addr_reg;
  logic [7:0]            len_reg;
  logic [2:0]            size_reg;
  logic [1:0]            burst_reg;
  logic                  err_reg;
  // Beats issued (reads) or accepted (writes); 9 bits so "all issued" = len+1.
  logic [8:0]            beat_reg;
  // Beats handed to the master on R; drives rlast.
  logic [7:0]            rcnt_reg;
  // A read was issued last cycle, so mem_rdata carries a beat this cycle.
  logic                  inflight_reg;
  logic [31:0]           skid_reg [2];
  logic                  rd_ptr_reg, wr_ptr_reg;
  logic [1:0]            count_reg;

  logic                  aw_grant, ar_grant;
  logic                  w_fire, w_last_beat;
  logic                  rd_issue;
  logic                  pop, pop_buf, push;
  logic [2:0]            occupancy;
  logic [31:0]           addr_next;

  // Next beat address. Sizes above 4 bytes are clamped to the 32-bit bus.
  // The reserved burst encoding walks like INCR (its error is flagged elsewhere).
  function automatic logic [31:0] beat_addr_next(
    input logic [31:0] addr,
    input logic [7:0]  len,
    input logic [2:0]  size,
    input logic [1:0]  burst
  );
    logic [1:0]  lg;
    logic [31:0] bytes;
    logic [31:0] mask;
    lg    = (size > 3'd2) ? 2'd2 : size[1:0];
    bytes = 32'd1 << lg;
    mask  = ((32'(len) + 32'd1) << lg) - 32'd1;
    case (burst)
      2'b00:   beat_addr_next = addr;
      2'b10:   beat_addr_next = (addr & ~mask) | ((addr + bytes) & mask);
      default: beat_addr_next = (addr & ~(bytes - 32'd1)) + bytes;
    endcase
  endfunction

  assign addr_next   = beat_addr_next(addr_reg, len_reg, size_reg, burst_reg);

  // When both address channels are valid, prio_w picks the winner; a lone
  // valid channel always wins.
  assign aw_grant    = (state_reg == IDLE) & s_awvalid & (~s_arvalid | prio_w_reg);
  assign ar_grant    = (state_reg == IDLE) & s_arvalid & (~s_awvalid | ~prio_w_reg);

  assign w_fire      = (state_reg == WDATA) & s_wvalid;
  assign w_last_beat = (beat_reg[7:0] == len_reg);

  // Read path: the beat arriving on mem_rdata counts as occupied space, and
  // is presented directly on R when the buffer is empty so the first beat
  // appears one cycle after the SRAM read.
  assign occupancy   = {1'b0, count_reg} + {2'b00, inflight_reg};
  assign s_rvalid    = (count_reg != 2'd0) | inflight_reg;
  assign s_rdata     = (count_reg != 2'd0) ? skid_reg[rd_ptr_reg] :
                       (inflight_reg ? mem_rdata : 32'd0);
  assign s_rlast     = s_rvalid & (rcnt_reg == len_reg);
  assign pop         = s_rvalid & s_rready;
  assign pop_buf     = pop & (count_reg != 2'd0);
  // Arriving beat bypasses the buffer only if it is consumed immediately.
  assign push        = inflight_reg & ~((count_reg == 2'd0) & pop);

  assign s_rid       = id_reg;
  assign s_bid       = id_reg;
  assign s_rresp     = err_reg ? RESP_SLVERR : RESP_OKAY;
  assign s_bresp     = err_reg ? RESP_SLVERR : RESP_OKAY;
  assign mem_addr    = addr_reg[MEM_AW+1:2];

  always_comb begin
    state_next = state_reg;
    s_awready  = 1'b0;
    s_arready  = 1'b0;
    s_wready   = 1'b0;
    s_bvalid   = 1'b0;
    mem_cs     = 1'b0;
    mem_we     = 4'd0;
    mem_wdata  = 32'd0;
    rd_issue   = 1'b0;
    case (state_reg)
      IDLE: begin
        s_awready = aw_grant;
        s_arready = ar_grant;
        if (aw_grant) begin
          state_next = WDATA;
        end else if (ar_grant) begin
          state_next = RDATA;
        end
      end
      WDATA: begin
        s_wready = 1'b1;
        if (s_wvalid) begin
          mem_cs    = 1'b1;
          mem_we    = err_reg ? 4'd0 : s_wstrb;
          mem_wdata = s_wdata;
          if (w_last_beat) begin
            state_next = WRESP;
          end
        end
      end
      WRESP: begin
        s_bvalid = 1'b1;
        if (s_bready) begin
          state_next = IDLE;
        end
      end
      RDATA: begin
        if ((beat_reg <= {1'b0, len_reg}) && (occupancy < 3'd2)) begin
          rd_issue = 1'b1;
          mem_cs   = 1'b1;
        end
        if (pop && s_rlast) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= IDLE;
      prio_w_reg   <= 1'b1;
      id_reg       <= '0;
      addr_reg     <= 32'd0;
      len_reg      <= 8'd0;
      size_reg     <= 3'd0;
      burst_reg    <= 2'd0;
      err_reg      <= 1'b0;
      beat_reg     <= 9'd0;
      rcnt_reg     <= 8'd0;
      inflight_reg <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      wr_ptr_reg   <= 1'b0;
      count_reg    <= 2'd0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= rd_issue;
      if (aw_grant) begin
        id_reg     <= s_awid;
        addr_reg   <= s_awaddr;
        len_reg    <= s_awlen;
        size_reg   <= s_awsize;
        burst_reg  <= s_awburst;
        err_reg    <= (s_awburst == 2'b11);
        beat_reg   <= 9'd0;
        rcnt_reg   <= 8'd0;
        prio_w_reg <= 1'b0;
      end else if (ar_grant) begin
        id_reg     <= s_arid;
        addr_reg   <= s_araddr;
        len_reg    <= s_arlen;
        size_reg   <= s_arsize;
        burst_reg  <= s_arburst;
        err_reg    <= (s_arburst == 2'b11);
        beat_reg   <= 9'd0;
        rcnt_reg   <= 8'd0;
        prio_w_reg <= 1'b1;
      end
      if (w_fire || rd_issue) begin
        addr_reg <= addr_next;
        beat_reg <= beat_reg + 9'd1;
      end
      // The beat counter decides the burst end; wlast is only cross-checked.
      if (w_fire && (s_wlast != w_last_beat)) begin
        err_reg <= 1'b1;
      end
      if (pop) begin
        rcnt_reg <= rcnt_reg + 8'd1;
      end
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop_buf) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop_buf};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        skid_reg[i] <= 32'd0;
      end
    end else if (push) begin
      skid_reg[wr_ptr_reg] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_axi_sram_slv.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_axi_sram_slv
//   Directed bench for axi_sram_slv with a behavioural single-port SRAM
//   (registered read). Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_axi_sram_slv;
  localparam int IDW = 6;
  localparam int MAW = 15;

  logic            clk = 1'b0;
  logic            rstn = 1'b1;
  logic [IDW-1:0]  s_awid = '0;
  logic [31:0]     s_awaddr = '0;
  logic [7:0]      s_awlen = '0;
  logic [2:0]      s_awsize = '0;
  logic [1:0]      s_awburst = '0;
  logic            s_awvalid = 1'b0;
  logic            s_awready;
  logic [31:0]     s_wdata = '0;
  logic [3:0]      s_wstrb = '0;
  logic            s_wlast = 1'b0;
  logic            s_wvalid = 1'b0;
  logic            s_wready;
  logic [IDW-1:0]  s_bid;
  logic [1:0]      s_bresp;
  logic            s_bvalid;
  logic            s_bready = 1'b0;
  logic [IDW-1:0]  s_arid = '0;
  logic [31:0]     s_araddr = '0;
  logic [7:0]      s_arlen = '0;
  logic [2:0]      s_arsize = '0;
  logic [1:0]      s_arburst = '0;
  logic            s_arvalid = 1'b0;
  logic            s_arready;
  logic [IDW-1:0]  s_rid;
  logic [31:0]     s_rdata;
  logic [1:0]      s_rresp;
  logic            s_rlast;
  logic            s_rvalid;
  logic            s_rready = 1'b0;
  logic            mem_cs;
  logic [3:0]      mem_we;
  logic [MAW-1:0]  mem_addr;
  logic [31:0]     mem_wdata;
  logic [31:0]     mem_rdata = '0;

  always #5 clk = ~clk;

  axi_sram_slv #(.ID_WIDTH(IDW), .MEM_AW(MAW)) dut (
    .clk(clk), .rstn(rstn),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
    .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Behavioural SRAM: byte writes, 1-cycle registered read.
  logic [31:0] sram [0:(1<<MAW)-1];
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we == 4'd0) begin
        mem_rdata <= sram[mem_addr];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  int          hs_wait;
  int          first_rv;
  int          last_pop;
  int          max_out;
  logic [3:0]  we_seen;
  logic [31:0] wbuf  [16];
  logic [3:0]  sbuf  [16];
  logic [31:0] exp_r [16];
  int          raddr_q [$];
  int          wrap_words [4] = '{32'h402, 32'h403, 32'h400, 32'h401};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic aw_set(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    s_awid = id; s_awaddr = addr; s_awlen = len; s_awsize = size; s_awburst = burst;
    s_awvalid = 1'b1;
  endtask

  task automatic ar_set(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst;
    s_arvalid = 1'b1;
  endtask

  task automatic wait_aw();
    hs_wait = 0;
    #1;
    while (!s_awready && hs_wait < 20) begin
      @(negedge clk); #1; hs_wait++;
    end
    check_val("awready", 32'(s_awready), 32'd1);
    @(negedge clk);
    s_awvalid = 1'b0;
  endtask

  task automatic wait_ar();
    hs_wait = 0;
    #1;
    while (!s_arready && hs_wait < 20) begin
      @(negedge clk); #1; hs_wait++;
    end
    check_val("arready", 32'(s_arready), 32'd1);
    @(negedge clk);
    s_arvalid = 1'b0;
  endtask

  // Called on the first negedge after the AW handshake.
  task automatic w_phase(input int len, input int bad_last);
    we_seen = 4'd0;
    for (int i = 0; i <= len; i++) begin
      s_wvalid = 1'b1;
      s_wdata  = wbuf[i];
      s_wstrb  = sbuf[i];
      s_wlast  = (i == len) && (bad_last == 0);
      #1;
      check_val("wready", 32'(s_wready), 32'd1);
      if (mem_cs) we_seen = we_seen | mem_we;
      @(negedge clk);
    end
    s_wvalid = 1'b0;
    s_wlast  = 1'b0;
  endtask

  // Called on the first negedge after the last W beat: bvalid must already be up.
  task automatic b_phase(input logic [1:0] resp, input logic [IDW-1:0] id);
    #1;
    check_val("bvalid", 32'(s_bvalid), 32'd1);
    check_val("bresp", 32'(s_bresp), 32'(resp));
    check_val("bid", 32'(s_bid), 32'(id));
    $display("write  id=%0h bresp=%0d", s_bid, s_bresp);
    s_bready = 1'b1;
    @(negedge clk);
    s_bready = 1'b0;
  endtask

  // Called on the first negedge after the AR handshake (cycle index 0).
  // mode 0: rready always high; mode 1: rready high on odd cycles only.
  task automatic r_phase(input int len, input logic [IDW-1:0] id, input logic [1:0] resp, input int mode);
    int nb, cyc, outs;
    nb = 0; cyc = 0; outs = 0;
    max_out = 0; first_rv = -1; last_pop = -1;
    raddr_q.delete();
    while (nb <= len && cyc < 300) begin
      s_rready = (mode == 0) ? 1'b1 : cyc[0];
      #1;
      if (cyc == 0) begin
        check_val("rd_issue_t1", 32'(mem_cs && (mem_we == 4'd0)), 32'd1);
        check_val("rvalid_t1", 32'(s_rvalid), 32'd0);
      end
      if (mem_cs && (mem_we == 4'd0)) begin
        outs++;
        raddr_q.push_back(int'(mem_addr));
      end
      if (s_rvalid && first_rv < 0) first_rv = cyc;
      if (s_rvalid && s_rready) begin
        check_val($sformatf("rdata[%0d]", nb), s_rdata, exp_r[nb]);
        check_val($sformatf("rlast[%0d]", nb), 32'(s_rlast), 32'(nb == len));
        check_val("rid", 32'(s_rid), 32'(id));
        check_val("rresp", 32'(s_rresp), 32'(resp));
        outs--;
        nb++;
        last_pop = cyc;
      end
      if (outs > max_out) max_out = outs;
      @(negedge clk);
      cyc++;
    end
    s_rready = 1'b0;
    check_val("r_beats", 32'(nb), 32'(len + 1));
    check_val("outstanding_le2", 32'(max_out <= 2), 32'd1);
    $display("read   id=%0h beats=%0d first_rvalid=%0d last_pop=%0d max_out=%0d", id, nb, first_rv, last_pop, max_out);
  endtask

  task automatic axi_write(input logic [IDW-1:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input logic [1:0] resp, input int bad_last);
    aw_set(id, addr, 8'(len), 3'd2, burst);
    wait_aw();
    w_phase(len, bad_last);
    b_phase(resp, id);
  endtask

  task automatic axi_read(input logic [IDW-1:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input logic [1:0] resp, input int mode);
    ar_set(id, addr, 8'(len), 3'd2, burst);
    wait_ar();
    r_phase(len, id, resp, mode);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset ----------------
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_bvalid", 32'(s_bvalid), 32'd0);
    check_val("rst_rvalid", 32'(s_rvalid), 32'd0);
    check_val("rst_wready", 32'(s_wready), 32'd0);
    check_val("rst_rlast", 32'(s_rlast), 32'd0);
    check_val("rst_mem_cs", 32'(mem_cs), 32'd0);
    check_val("rst_mem_we", 32'(mem_we), 32'd0);
    check_val("rst_bresp", 32'(s_bresp), 32'd0);
    check_val("rst_rresp", 32'(s_rresp), 32'd0);
    check_val("rst_bid", 32'(s_bid), 32'd0);
    check_val("rst_rid", 32'(s_rid), 32'd0);
    check_val("rst_rdata", s_rdata, 32'd0);
    check_val("rst_awready_idle", 32'(s_awready), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // ---- simultaneous AW/AR from reset: write first; single write 0xCAFEBABE @0x100 ----
    wbuf[0] = 32'hCAFEBABE; sbuf[0] = 4'hF;
    aw_set(6'h11, 32'h100, 8'd0, 3'd2, 2'b01);
    ar_set(6'h22, 32'h100, 8'd0, 3'd2, 2'b01);
    #1;
    check_val("arb1_awready", 32'(s_awready), 32'd1);
    check_val("arb1_arready", 32'(s_arready), 32'd0);
    wait_aw();
    w_phase(0, 0);
    b_phase(2'b00, 6'h11);

    // ---- next simultaneous pair: read wins ----
    wbuf[0] = 32'h5A5A0300; sbuf[0] = 4'hF;
    aw_set(6'h12, 32'h300, 8'd0, 3'd2, 2'b01);
    #1;
    check_val("arb2_arready", 32'(s_arready), 32'd1);
    check_val("arb2_awready", 32'(s_awready), 32'd0);
    wait_ar();
    check_val("ar_after_b_wait", 32'(hs_wait), 32'd0);
    exp_r[0] = 32'hCAFEBABE;
    r_phase(0, 6'h22, 2'b00, 0);
    check_val("single_first_rvalid", 32'(first_rv), 32'd1);
    wait_aw();
    check_val("aw_after_rlast_wait", 32'(hs_wait), 32'd0);
    w_phase(0, 0);
    b_phase(2'b00, 6'h12);

    // ---- INCR len=3 with partial strobe on beat 2 ----
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hFFFFFFFF; sbuf[i] = 4'hF; end
    axi_write(6'h01, 32'h200, 3, 2'b01, 2'b00, 0);
    wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3; wbuf[3] = 32'd4;
    sbuf[1] = 4'b0011;
    axi_write(6'h02, 32'h200, 3, 2'b01, 2'b00, 0);
    exp_r[0] = 32'd1; exp_r[1] = 32'hFFFF0002; exp_r[2] = 32'd3; exp_r[3] = 32'd4;
    axi_read(6'h03, 32'h200, 3, 2'b01, 2'b00, 0);
    check_val("incr_first_rvalid", 32'(first_rv), 32'd1);
    check_val("incr_no_bubbles", 32'(last_pop), 32'd4);

    // ---- WRAP len=3 read @0x1008 ----
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0 + 32'(i); sbuf[i] = 4'hF; end
    axi_write(6'h04, 32'h1000, 3, 2'b01, 2'b00, 0);
    exp_r[0] = 32'hA2; exp_r[1] = 32'hA3; exp_r[2] = 32'hA0; exp_r[3] = 32'hA1;
    axi_read(6'h05, 32'h1008, 3, 2'b10, 2'b00, 0);
    check_val("wrap_first_rvalid", 32'(first_rv), 32'd1);
    check_val("wrap_n_addr", 32'(raddr_q.size()), 32'd4);
    for (int k = 0; k < 4 && k < raddr_q.size(); k++) begin
      check_val($sformatf("wrap_addr[%0d]", k), 32'(raddr_q[k]), 32'(wrap_words[k]));
    end

    // ---- len=7 read with rready toggling ----
    for (int i = 0; i < 8; i++) begin wbuf[i] = 32'h80000000 + 32'(i); sbuf[i] = 4'hF; exp_r[i] = wbuf[i]; end
    axi_write(6'h06, 32'h2000, 7, 2'b01, 2'b00, 0);
    axi_read(6'h07, 32'h2000, 7, 2'b01, 2'b00, 1);

    // ---- reserved burst write: no byte enables, SLVERR ----
    wbuf[0] = 32'h12345678; sbuf[0] = 4'hF;
    axi_write(6'h08, 32'h3000, 0, 2'b01, 2'b00, 0);
    wbuf[0] = 32'hDEADBEEF;
    axi_write(6'h09, 32'h3000, 0, 2'b11, 2'b10, 0);
    check_val("rsvd_mem_we", 32'(we_seen), 32'd0);
    exp_r[0] = 32'h12345678;
    axi_read(6'h0A, 32'h3000, 0, 2'b01, 2'b00, 0);

    // ---- wlast low on the final beat -> SLVERR ----
    wbuf[0] = 32'h1; wbuf[1] = 32'h2; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    axi_write(6'h0B, 32'h4000, 1, 2'b01, 2'b10, 1);

    // ---- reset in the middle of a 16-beat read ----
    ar_set(6'h0C, 32'h2000, 8'd15, 3'd2, 2'b01);
    wait_ar();
    s_rready = 1'b1;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    #1;
    check_val("midrst_rvalid", 32'(s_rvalid), 32'd0);
    check_val("midrst_mem_cs", 32'(mem_cs), 32'd0);
    check_val("midrst_rlast", 32'(s_rlast), 32'd0);
    check_val("midrst_rdata", s_rdata, 32'd0);
    s_rready = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    exp_r[0] = 32'hCAFEBABE;
    axi_read(6'h0D, 32'h100, 0, 2'b01, 2'b00, 0);
    check_val("postrst_first_rvalid", 32'(first_rv), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
